// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int BTN_STARTSTOP = 0;
    localparam int BTN_LAP       = 1;
    localparam int BTN_CLEAR     = 2;

    localparam int NUM_DIGITS = 6;

    // Digit order is c0,c1,s0,s1,m0,m1; the tens of seconds and tens of minutes count mod 6.
    function automatic int digit_mod(input int idx);
        return ((idx == 3) || (idx == 5)) ? 6 : 10;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter with synchronous clear and combinational carry-out.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    localparam bcd_t LAST = bcd_t'(MOD - 1);

    bcd_t q_reg, q_next;

    // Wrap on >= LAST so an out-of-range value can never persist.
    always_comb begin
        q_next = q_reg;
        if (clr) begin
            q_next = '0;
        end else if (inc) begin
            q_next = (q_reg >= LAST) ? '0 : q_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q     = q_reg;
    assign carry = inc && (q_reg == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch top: start/stop/lap/clear FSM, 1/100 s prescaler, BCD time chain, lap hold and display register.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [2:0]  btn_pls,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic [1:0]  state
);

    localparam int PSC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_CYCLES - 1);

    state_t             state_reg, state_next;
    logic [PSC_W-1:0]   psc_reg, psc_next;
    logic [23:0]        lap_reg, lap_next;
    logic [23:0]        disp_reg, disp_next;
    logic               running_reg, lap_active_reg;

    logic               go_pls, lap_pls, clr_pls;
    logic               lap_capture, cnt_clr, counting, tick;
    logic [23:0]        cnt_bcd;
    logic [NUM_DIGITS:0] inc_chain;
    logic               unused_wrap;

    // Only the highest-priority pulse survives; lower ones are masked off.
    assign go_pls  = btn_pls[BTN_STARTSTOP];
    assign lap_pls = btn_pls[BTN_LAP] & ~btn_pls[BTN_STARTSTOP];
    assign clr_pls = btn_pls[BTN_CLEAR] & ~btn_pls[BTN_LAP] & ~btn_pls[BTN_STARTSTOP];

    always_comb begin
        state_next  = state_reg;
        lap_capture = 1'b0;
        cnt_clr     = 1'b0;
        case (state_reg)
            IDLE: if (go_pls) state_next = RUN;
            RUN: begin
                if (go_pls) begin
                    state_next = STOP;
                end else if (lap_pls) begin
                    state_next  = LAP;
                    lap_capture = 1'b1;
                end
            end
            LAP: begin
                if (go_pls) state_next = STOP;
                else if (lap_pls) state_next = RUN;
            end
            STOP: begin
                if (go_pls) begin
                    state_next = RUN;
                end else if (clr_pls) begin
                    state_next = IDLE;
                    cnt_clr    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Prescaler holds in STOP so a pause does not lose the partial 1/100 s.
    assign counting = (state_reg == RUN) || (state_reg == LAP);
    assign tick     = counting && (psc_reg == PSC_LAST);

    always_comb begin
        psc_next = psc_reg;
        if (cnt_clr || (state_reg == IDLE)) begin
            psc_next = '0;
        end else if (counting) begin
            psc_next = tick ? '0 : psc_reg + PSC_W'(1);
        end
    end

    assign inc_chain[0] = tick;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_cnt #(
                .MOD (digit_mod(gi))
            ) u_digit (
                .clk   (clk),
                .n_rst (n_rst),
                .clr   (cnt_clr),
                .inc   (inc_chain[gi]),
                .q     (cnt_bcd[gi*4 +: 4]),
                .carry (inc_chain[gi+1])
            );
        end
    endgenerate

    // Carry out of m1 is dropped: 59:59.99 simply wraps to zero.
    assign unused_wrap = inc_chain[NUM_DIGITS];

    assign lap_next  = lap_capture ? cnt_bcd : lap_reg;
    assign disp_next = (state_reg == LAP) ? lap_reg : cnt_bcd;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg      <= IDLE;
            psc_reg        <= '0;
            lap_reg        <= '0;
            disp_reg       <= '0;
            running_reg    <= 1'b0;
            lap_active_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            psc_reg        <= psc_next;
            lap_reg        <= lap_next;
            disp_reg       <= disp_next;
            running_reg    <= (state_next == RUN) || (state_next == LAP);
            lap_active_reg <= (state_next == LAP);
        end
    end

    assign disp_bcd   = disp_reg;
    assign running    = running_reg;
    assign lap_active = lap_active_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl with TICK_CYCLES = 4.
module tb_stopwatch_ctrl;

    logic        clk;
    logic        n_rst;
    logic [2:0]  btn_pls;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic [1:0]  state;

    typedef struct {
        string       name;
        logic [23:0] disp;
        logic [1:0]  st;
        logic        run;
        logic        lap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic chk_req;
    int   checks;
    int   errors;

    stopwatch_ctrl #(
        .TICK_CYCLES (4)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .btn_pls    (btn_pls),
        .disp_bcd   (disp_bcd),
        .running    (running),
        .lap_active (lap_active),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation per strobe and compares on the falling edge.
    always @(negedge clk) begin
        if (chk_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: strobe with no expected entry");
            end else begin
                mon_e = exp_q.pop_front();
                if ({disp_bcd, state, running, lap_active} !==
                    {mon_e.disp, mon_e.st, mon_e.run, mon_e.lap}) begin
                    errors++;
                    $display("FAIL %s: got disp=%h state=%0d running=%b lap_active=%b, want disp=%h state=%0d running=%b lap_active=%b",
                             mon_e.name, disp_bcd, state, running, lap_active,
                             mon_e.disp, mon_e.st, mon_e.run, mon_e.lap);
                end else begin
                    $display("ok   %s: disp=%h state=%0d running=%b lap_active=%b",
                             mon_e.name, disp_bcd, state, running, lap_active);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] b);
        btn_pls = b;
        step(1);
        btn_pls = 3'b000;
    endtask

    task automatic expect_out(input string nm, input logic [23:0] d, input logic [1:0] s,
                              input logic r, input logic l);
        exp_t e;
        e.name = nm;
        e.disp = d;
        e.st   = s;
        e.run  = r;
        e.lap  = l;
        exp_q.push_back(e);
        chk_req = 1'b1;
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        chk_req = 1'b0;
        n_rst   = 1'b0;
        btn_pls = 3'b000;

        // Reset and idle behaviour
        step(3);
        expect_out("reset",         24'h000000, 2'd0, 1'b0, 1'b0);
        n_rst = 1'b1;
        step(100);
        expect_out("idle_100",      24'h000000, 2'd0, 1'b0, 1'b0);
        pulse(3'b100);
        expect_out("idle_clear",    24'h000000, 2'd0, 1'b0, 1'b0);
        pulse(3'b010);
        expect_out("idle_lap",      24'h000000, 2'd0, 1'b0, 1'b0);

        // Start, count, stop and hold
        pulse(3'b001);
        expect_out("start",         24'h000000, 2'd1, 1'b1, 1'b0);
        step(101);
        expect_out("run_25",        24'h000025, 2'd1, 1'b1, 1'b0);
        pulse(3'b001);
        expect_out("stop",          24'h000025, 2'd3, 1'b0, 1'b0);
        step(50);
        expect_out("stop_hold",     24'h000025, 2'd3, 1'b0, 1'b0);

        // Resume, second rollover, full wrap
        pulse(3'b001);
        expect_out("resume",        24'h000025, 2'd1, 1'b1, 1'b0);
        step(295);
        expect_out("at_99",         24'h000099, 2'd1, 1'b1, 1'b0);
        step(4);
        expect_out("at_100",        24'h000100, 2'd1, 1'b1, 1'b0);
        pulse(3'b001);
        expect_out("stop_100",      24'h000100, 2'd3, 1'b0, 1'b0);
        dut.g_digit[0].u_digit.q_reg = 4'd9;
        dut.g_digit[1].u_digit.q_reg = 4'd9;
        dut.g_digit[2].u_digit.q_reg = 4'd9;
        dut.g_digit[3].u_digit.q_reg = 4'd5;
        dut.g_digit[4].u_digit.q_reg = 4'd9;
        dut.g_digit[5].u_digit.q_reg = 4'd5;
        step(1);
        expect_out("preload_max",   24'h595999, 2'd3, 1'b0, 1'b0);
        pulse(3'b001);
        expect_out("resume_max",    24'h595999, 2'd1, 1'b1, 1'b0);
        step(2);
        expect_out("pre_wrap",      24'h595999, 2'd1, 1'b1, 1'b0);
        step(1);
        expect_out("wrap_zero",     24'h000000, 2'd1, 1'b1, 1'b0);

        // Lap freeze and release
        step(40);
        expect_out("run_10",        24'h000010, 2'd1, 1'b1, 1'b0);
        pulse(3'b010);
        expect_out("lap_enter",     24'h000010, 2'd2, 1'b1, 1'b1);
        step(20);
        expect_out("lap_frozen",    24'h000010, 2'd2, 1'b1, 1'b1);
        pulse(3'b010);
        expect_out("lap_exit",      24'h000010, 2'd1, 1'b1, 1'b0);
        step(1);
        expect_out("lap_live_15",   24'h000015, 2'd1, 1'b1, 1'b0);

        // Clear ignored while running, honoured from STOP
        pulse(3'b100);
        expect_out("run_clear_ign", 24'h000016, 2'd1, 1'b1, 1'b0);
        step(4);
        expect_out("run_17",        24'h000017, 2'd1, 1'b1, 1'b0);
        pulse(3'b001);
        expect_out("stop_17",       24'h000017, 2'd3, 1'b0, 1'b0);
        pulse(3'b100);
        expect_out("clear_state",   24'h000017, 2'd0, 1'b0, 1'b0);
        step(1);
        expect_out("clear_disp",    24'h000000, 2'd0, 1'b0, 1'b0);

        // Simultaneous pulses and reset mid-run
        pulse(3'b001);
        expect_out("restart",       24'h000000, 2'd1, 1'b1, 1'b0);
        step(5);
        expect_out("run_1",         24'h000001, 2'd1, 1'b1, 1'b0);
        pulse(3'b011);
        expect_out("prio_011",      24'h000001, 2'd3, 1'b0, 1'b0);
        pulse(3'b101);
        expect_out("prio_101",      24'h000001, 2'd1, 1'b1, 1'b0);
        step(3);
        expect_out("run_2",         24'h000002, 2'd1, 1'b1, 1'b0);
        step(160);
        expect_out("run_42",        24'h000042, 2'd1, 1'b1, 1'b0);
        n_rst = 1'b0;
        step(1);
        expect_out("reset_midrun",  24'h000000, 2'd0, 1'b0, 1'b0);
        n_rst = 1'b1;
        step(10);
        expect_out("after_reset",   24'h000000, 2'd0, 1'b0, 1'b0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries never compared, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
